wb_uart_lite: RTL and testbench

Synthesizable Wishbone-slave UART (8N1) that connects to the SoC's 24-bit UART Wishbone port and interrupt input. Used in builds without DPI modules, and on FPGA targets, in place of the TCP-backed UART model. Provides TX/RX FIFOs, a programmable bit divisor and a level interrupt. The serial pins go to the board, or are looped back in the test bench.

---
 rtl/wb_uart_lite_pkg.sv | 24 ++
 rtl/uart_lite_fifo.sv | 52 +++++
 rtl/wb_uart_lite.sv | 228 ++++++++++++++++++++++
 tb/tb_wb_uart_lite.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_uart_lite_pkg.sv
// Shared definitions for the wb_uart_lite Wishbone UART: register indices,
// STATUS bit positions, serial state encodings and the divisor clamp.
package wb_uart_lite_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_CONTROL = 2'd2;
    localparam logic [1:0] REG_DIVISOR = 2'd3;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_TX_FULL     = 1;
    localparam int ST_TX_IDLE     = 2;
    localparam int ST_RX_OVERRUN  = 3;
    localparam int ST_FRAMING_ERR = 4;

    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    // Shorter bit periods cannot hold the mid-bit RX sampling point.
    function automatic logic [15:0] clamp_div(input logic [15:0] d);
        return (d < 16'd2) ? 16'd2 : d;
    endfunction

endpackage

// File: rtl/uart_lite_fifo.sv
// Synchronous FIFO with a combinational head: the popped word is valid in the
// same cycle as the pop. A push while full succeeds only if a pop frees space.
module uart_lite_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_pop_data,
    output logic                  o_full,
    output logic                  o_empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_empty    = (r_count == '0);
    assign o_full     = r_count[DEPTH_LOG2];
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_do_pop   = i_pop & ~o_empty;
    assign w_do_push  = i_push & (~o_full | w_do_pop);

    // Pointer and occupancy tracking.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
            if (w_do_push & ~w_do_pop)      r_count <= r_count + CNT_ONE;
            else if (w_do_pop & ~w_do_push) r_count <= r_count - CNT_ONE;
        end
    end

    // Storage array.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
    end

endmodule

// File: rtl/wb_uart_lite.sv
// Wishbone classic slave UART (8N1) with TX/RX FIFOs, programmable divisor
// and a registered level interrupt.
module wb_uart_lite
    import wb_uart_lite_pkg::*;
#(
    parameter int          ADDR_WIDTH      = 24,
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] DEFAULT_DIVISOR = 16'd433
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_we_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  int_o,
    output logic                  uart_tx_o,
    input  logic                  uart_rx_i
);
    logic r_ack, r_err, r_int, r_overrun, r_frame_err;
    logic [31:0] r_dat;
    logic [1:0]  r_ctrl;
    logic [15:0] r_div;
    logic w_req, w_acc, w_tx_push, w_rx_pop, w_stat_rd, w_tx_idle, w_unused;
    logic [1:0]  w_idx;
    logic [31:0] w_rd_data, w_status;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty, w_rx_ovf;
    logic [7:0] w_tx_dout, w_rx_dout;

    tx_state_e r_tx_state, w_tx_state_nx;
    logic [15:0] r_tx_cnt, w_tx_cnt_nx, r_tx_div, w_tx_div_nx;
    logic [2:0]  r_tx_bit, w_tx_bit_nx;
    logic [7:0]  r_tx_shift, w_tx_shift_nx;
    logic r_tx_line, w_tx_line_nx, w_tx_pop, w_tx_done;

    rx_state_e r_rx_state, w_rx_state_nx;
    logic [15:0] r_rx_cnt, w_rx_cnt_nx, r_rx_div, w_rx_div_nx, w_rx_half;
    logic [2:0]  r_rx_bit, w_rx_bit_nx;
    logic [7:0]  r_rx_shift, w_rx_shift_nx;
    logic [1:0]  r_rx_sync;
    logic r_rx_last, w_rx_line, w_rx_push, w_rx_ferr;

    // A response cycle is never followed by another response.
    assign w_req     = wb_cyc_i & wb_stb_i & ~r_ack & ~r_err;
    assign w_acc     = w_req & (wb_adr_i[ADDR_WIDTH-1:4] == '0);
    assign w_idx     = wb_adr_i[3:2];
    assign w_tx_push = w_acc & wb_we_i & (w_idx == REG_DATA) & wb_sel_i[0];
    assign w_rx_pop  = w_acc & ~wb_we_i & (w_idx == REG_DATA);
    assign w_stat_rd = w_acc & ~wb_we_i & (w_idx == REG_STATUS);
    assign w_tx_idle = w_tx_empty & (r_tx_state == TX_IDLE);
    assign w_rx_ovf  = w_rx_push & w_rx_full & ~w_rx_pop;
    assign w_status  = {27'd0, r_frame_err, r_overrun, w_tx_idle, w_tx_full, ~w_rx_empty};
    assign w_unused  = ^{wb_adr_i[1:0], wb_dat_i[31:16], wb_sel_i[3:2]};

    assign wb_ack_o  = r_ack;
    assign wb_err_o  = r_err;
    assign wb_dat_o  = r_dat;
    assign int_o     = r_int;
    assign uart_tx_o = r_tx_line;

    uart_lite_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
        .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_push(w_tx_push), .i_push_data(wb_dat_i[7:0]),
        .i_pop(w_tx_pop), .o_pop_data(w_tx_dout), .o_full(w_tx_full), .o_empty(w_tx_empty));

    uart_lite_fifo #(.DATA_WIDTH(8), .DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
        .i_clk(wb_clk_i), .i_rst(wb_rst_i), .i_push(w_rx_push), .i_push_data(w_rx_shift_nx),
        .i_pop(w_rx_pop), .o_pop_data(w_rx_dout), .o_full(w_rx_full), .o_empty(w_rx_empty));

    // Register read multiplexer.
    always_comb begin
        w_rd_data = 32'd0;
        case (w_idx)
            REG_DATA:    w_rd_data = w_rx_empty ? 32'd0 : {24'd0, w_rx_dout};
            REG_STATUS:  w_rd_data = w_status;
            REG_CONTROL: w_rd_data = {30'd0, r_ctrl};
            REG_DIVISOR: w_rd_data = {16'd0, r_div};
            default:     w_rd_data = 32'd0;
        endcase
    end

    // Bus response, control registers, sticky flags and interrupt.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_ack <= 1'b0; r_err <= 1'b0; r_dat <= 32'd0; r_int <= 1'b0;
            r_ctrl <= 2'd0; r_div <= DEFAULT_DIVISOR;
            r_overrun <= 1'b0; r_frame_err <= 1'b0;
        end else begin
            r_ack <= w_acc;
            r_err <= w_req & ~w_acc;
            r_dat <= (w_acc & ~wb_we_i) ? w_rd_data : 32'd0;
            if (w_acc & wb_we_i & (w_idx == REG_CONTROL) & wb_sel_i[0]) r_ctrl <= wb_dat_i[1:0];
            if (w_acc & wb_we_i & (w_idx == REG_DIVISOR))
                r_div <= clamp_div({wb_sel_i[1] ? wb_dat_i[15:8] : r_div[15:8],
                                    wb_sel_i[0] ? wb_dat_i[7:0]  : r_div[7:0]});
            // A new event in the same cycle as a STATUS read must not be lost.
            r_overrun   <= w_rx_ovf  | (r_overrun   & ~w_stat_rd);
            r_frame_err <= w_rx_ferr | (r_frame_err & ~w_stat_rd);
            r_int <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_idle);
        end
    end

    // TX next-state logic; a frame boundary with queued data chains straight into START.
    always_comb begin
        w_tx_state_nx = r_tx_state; w_tx_cnt_nx = r_tx_cnt + 16'd1; w_tx_bit_nx = r_tx_bit;
        w_tx_shift_nx = r_tx_shift; w_tx_div_nx = r_tx_div; w_tx_line_nx = r_tx_line;
        w_tx_pop = 1'b0; w_tx_done = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nx = 16'd0; w_tx_line_nx = 1'b1; w_tx_done = 1'b1;
            end
            TX_START: begin
                if (r_tx_cnt == r_tx_div) begin
                    w_tx_cnt_nx = 16'd0; w_tx_bit_nx = 3'd0;
                    w_tx_state_nx = TX_DATA; w_tx_line_nx = r_tx_shift[0];
                end else begin
                    w_tx_state_nx = TX_START;
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == r_tx_div) begin
                    w_tx_cnt_nx = 16'd0;
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nx = TX_STOP; w_tx_line_nx = 1'b1;
                    end else begin
                        w_tx_bit_nx = r_tx_bit + 3'd1;
                        w_tx_shift_nx = {1'b0, r_tx_shift[7:1]};
                        w_tx_line_nx = r_tx_shift[1];
                    end
                end else begin
                    w_tx_state_nx = TX_DATA;
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == r_tx_div) begin
                    w_tx_cnt_nx = 16'd0; w_tx_state_nx = TX_IDLE; w_tx_done = 1'b1;
                end else begin
                    w_tx_state_nx = TX_STOP;
                end
            end
            default: begin
                w_tx_state_nx = TX_IDLE; w_tx_line_nx = 1'b1;
            end
        endcase
        if (w_tx_done & ~w_tx_empty) begin
            w_tx_pop = 1'b1; w_tx_shift_nx = w_tx_dout; w_tx_div_nx = r_div;
            w_tx_state_nx = TX_START; w_tx_line_nx = 1'b0; w_tx_cnt_nx = 16'd0;
        end else begin
            w_tx_pop = 1'b0;
        end
    end

    // TX state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_tx_state <= TX_IDLE; r_tx_cnt <= 16'd0; r_tx_bit <= 3'd0;
            r_tx_shift <= 8'd0; r_tx_div <= 16'd0; r_tx_line <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nx; r_tx_cnt <= w_tx_cnt_nx; r_tx_bit <= w_tx_bit_nx;
            r_tx_shift <= w_tx_shift_nx; r_tx_div <= w_tx_div_nx; r_tx_line <= w_tx_line_nx;
        end
    end

    assign w_rx_line = r_rx_sync[1];
    assign w_rx_half = (r_rx_div >> 1) + {15'd0, r_rx_div[0]};

    // RX next-state logic: half-bit start qualification, then mid-bit sampling.
    always_comb begin
        w_rx_state_nx = r_rx_state; w_rx_cnt_nx = r_rx_cnt + 16'd1; w_rx_bit_nx = r_rx_bit;
        w_rx_shift_nx = r_rx_shift; w_rx_div_nx = r_rx_div;
        w_rx_push = 1'b0; w_rx_ferr = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_cnt_nx = 16'd0;
                if (r_rx_last & ~w_rx_line) begin
                    w_rx_state_nx = RX_START; w_rx_div_nx = r_div;
                end else begin
                    w_rx_state_nx = RX_IDLE;
                end
            end
            RX_START: begin
                if (r_rx_cnt == w_rx_half) begin
                    w_rx_cnt_nx = 16'd0; w_rx_bit_nx = 3'd0;
                    w_rx_state_nx = w_rx_line ? RX_IDLE : RX_DATA;
                end else begin
                    w_rx_state_nx = RX_START;
                end
            end
            RX_DATA: begin
                if (r_rx_cnt == r_rx_div) begin
                    w_rx_cnt_nx = 16'd0;
                    w_rx_shift_nx = {w_rx_line, r_rx_shift[7:1]};
                    w_rx_bit_nx = r_rx_bit + 3'd1;
                    w_rx_state_nx = (r_rx_bit == 3'd7) ? RX_STOP : RX_DATA;
                end else begin
                    w_rx_state_nx = RX_DATA;
                end
            end
            RX_STOP: begin
                if (r_rx_cnt == r_rx_div) begin
                    w_rx_cnt_nx = 16'd0; w_rx_state_nx = RX_IDLE;
                    w_rx_push = w_rx_line; w_rx_ferr = ~w_rx_line;
                end else begin
                    w_rx_state_nx = RX_STOP;
                end
            end
            default: w_rx_state_nx = RX_IDLE;
        endcase
    end

    // RX synchronizer and state register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_rx_sync <= 2'b11; r_rx_last <= 1'b1;
            r_rx_state <= RX_IDLE; r_rx_cnt <= 16'd0; r_rx_bit <= 3'd0;
            r_rx_shift <= 8'd0; r_rx_div <= 16'd0;
        end else begin
            r_rx_sync <= {r_rx_sync[0], uart_rx_i}; r_rx_last <= w_rx_line;
            r_rx_state <= w_rx_state_nx; r_rx_cnt <= w_rx_cnt_nx; r_rx_bit <= w_rx_bit_nx;
            r_rx_shift <= w_rx_shift_nx; r_rx_div <= w_rx_div_nx;
        end
    end

endmodule

// File: tb/tb_wb_uart_lite.sv
// Directed plus randomized bench for wb_uart_lite; expected RX contents and
// sticky flags come from a byte-queue model of the UART's documented behaviour.
module tb_wb_uart_lite;
    localparam logic [23:0] A_DATA   = 24'h000000;
    localparam logic [23:0] A_STATUS = 24'h000004;
    localparam logic [23:0] A_CTRL   = 24'h000008;
    localparam logic [23:0] A_DIV    = 24'h00000C;

    logic clk, rst, we, stb, cyc, ack, err, irq, txo, rxi, loop_en, rx_drv;
    logic [23:0] adr;
    logic [31:0] wdat, rdat;
    logic [3:0]  sel;
    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] rx_q[$];
    logic m_ovf  = 1'b0;
    logic m_ferr = 1'b0;

    assign rxi = loop_en ? txo : rx_drv;

    wb_uart_lite dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_dat_o(rdat),
        .wb_we_i(we), .wb_sel_i(sel), .wb_stb_i(stb), .wb_cyc_i(cyc), .wb_ack_o(ack),
        .wb_err_o(err), .int_o(irq), .uart_tx_o(txo), .uart_rx_i(rxi));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic bus(input logic [23:0] a, input logic w, input logic [31:0] d,
                       output logic [31:0] rd, output logic k, output logic e);
        @(posedge clk); #1;
        adr = a; we = w; wdat = d; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        @(posedge clk); #1;
        rd = rdat; k = ack; e = err;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [23:0] a, input logic [31:0] d);
        logic [31:0] rd; logic k, e;
        bus(a, 1'b1, d, rd, k, e);
        check({tag, "_ack"}, {31'd0, k}, 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [23:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic k, e;
        bus(a, 1'b0, 32'd0, rd, k, e);
        check({tag, "_ack"}, {31'd0, k}, 32'd1);
        check(tag, rd, exp);
    endtask

    // Only used once the transmitter has drained, so tx_idle=1 and tx_full=0.
    function automatic logic [31:0] exp_status();
        return {27'd0, m_ferr, m_ovf, 1'b1, 1'b0, (rx_q.size() != 0)};
    endfunction

    task automatic chk_status(input string tag);
        rd_chk(tag, A_STATUS, exp_status());
        m_ovf = 1'b0; m_ferr = 1'b0;
    endtask

    task automatic chk_data(input string tag);
        logic [31:0] exp;
        exp = 32'd0;
        if (rx_q.size() != 0) exp = {24'd0, rx_q.pop_front()};
        rd_chk(tag, A_DATA, exp);
    endtask

    task automatic model_rx(input logic [7:0] b);
        if (rx_q.size() < 16) rx_q.push_back(b);
        else m_ovf = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        wr("tx_push", A_DATA, {24'd0, b});
        model_rx(b);
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int div);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1; rx_drv = f[i];
            repeat (div) @(posedge clk);
        end
        @(posedge clk); #1; rx_drv = 1'b1;
        if (stop_bit) model_rx(b);
        else m_ferr = 1'b1;
    endtask

    task automatic wait_tx_low(output logic found);
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            @(posedge clk); #1;
            if (txo === 1'b0) found = 1'b1;
        end
    endtask

    initial begin
        logic found;
        logic [10:0] frame;
        logic [5:0] pat;
        logic [31:0] rd; logic k, e;

        rst = 1'b1; we = 1'b0; stb = 1'b0; cyc = 1'b0; sel = 4'h0;
        adr = 24'd0; wdat = 32'd0; loop_en = 1'b0; rx_drv = 1'b1;
        repeat (3) @(posedge clk); #1;
        check("rst_ack", {31'd0, ack}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_dat", rdat, 32'd0);
        check("rst_int", {31'd0, irq}, 32'd0);
        check("rst_tx",  {31'd0, txo}, 32'd1);
        rst = 1'b0;
        rd_chk("rst_status", A_STATUS, 32'h4);
        rd_chk("rst_div", A_DIV, 32'd433);
        rd_chk("rst_ctrl", A_CTRL, 32'd0);

        // TX waveform for 0x55 at 4 clocks per bit.
        wr("div3", A_DIV, 32'd3);
        wr("tx55", A_DATA, 32'h55);
        wait_tx_low(found);
        check("tx_start_seen", {31'd0, found}, 32'd1);
        frame = {2'b11, 8'h55, 1'b0};
        for (int t = 0; t <= 40; t++) begin
            if (t > 0) begin @(posedge clk); #1; end
            check($sformatf("tx_wave_%0d", t), {31'd0, txo}, {31'd0, frame[t / 4]});
        end
        repeat (2) @(posedge clk);
        rd_chk("tx_idle_after", A_STATUS, 32'h4);

        // Reset in the middle of a frame.
        wr("txf0", A_DATA, 32'hF0);
        wait_tx_low(found);
        check("tx_f0_seen", {31'd0, found}, 32'd1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_tx", {31'd0, txo}, 32'd1);
        @(posedge clk); #1 rst = 1'b0;
        rd_chk("rst_mid_status", A_STATUS, 32'h4);
        rd_chk("rst_mid_div", A_DIV, 32'd433);

        // Loopback with RX interrupt.
        loop_en = 1'b1;
        wr("lb_div", A_DIV, 32'd3);
        wr("lb_ctrl", A_CTRL, 32'd1);
        repeat (2) @(posedge clk); #1;
        check("int_empty", {31'd0, irq}, 32'd0);
        send(8'hA3); send(8'h00); send(8'hFF);
        repeat (3 * 40 + 40) @(posedge clk); #1;
        check("int_rx", {31'd0, irq}, 32'd1);
        chk_status("lb_status");
        for (int j = 0; j < 4; j++) chk_data("lb_data");
        repeat (2) @(posedge clk); #1;
        check("int_drained", {31'd0, irq}, 32'd0);
        wr("ctrl_txint", A_CTRL, 32'd2);
        rd_chk("ctrl_rb", A_CTRL, 32'd2);
        repeat (2) @(posedge clk); #1;
        check("int_txidle", {31'd0, irq}, 32'd1);
        wr("ctrl_off", A_CTRL, 32'd0);
        repeat (2) @(posedge clk); #1;
        check("int_off", {31'd0, irq}, 32'd0);

        // Overrun: 17 bytes into a 16-entry RX FIFO.
        for (int j = 1; j <= 17; j++) send(8'(j));
        repeat (17 * 40 + 60) @(posedge clk);
        chk_status("ovr_status");
        for (int j = 0; j < 16; j++) chk_data("ovr_data");
        chk_status("ovr_cleared");

        // Randomized loopback traffic at random divisors.
        for (int it = 0; it < 3; it++) begin
            int d, n;
            d = int'($urandom_range(7, 2));
            n = int'($urandom_range(6, 1));
            wr("rnd_div", A_DIV, 32'(d));
            rd_chk("rnd_div_rb", A_DIV, 32'(d));
            for (int j = 0; j < n; j++) send(8'($urandom_range(255, 0)));
            repeat ((n * 10 + 4) * (d + 1) + 20) @(posedge clk);
            chk_status("rnd_status");
            for (int j = 0; j <= n; j++) chk_data("rnd_data");
        end

        // Externally driven RX: glitch, good frame, framing error.
        loop_en = 1'b0;
        wr("ext_div", A_DIV, 32'd7);
        @(posedge clk); #1 rx_drv = 1'b0;
        @(posedge clk); #1 rx_drv = 1'b1;
        repeat (30) @(posedge clk);
        chk_status("glitch_status");
        drive_frame(8'($urandom_range(255, 0)), 1'b1, 7);
        repeat (20) @(posedge clk);
        chk_status("ext_good_status");
        chk_data("ext_good_data");
        drive_frame(8'h3C, 1'b0, 7);
        repeat (20) @(posedge clk);
        chk_status("ferr_status");
        chk_status("ferr_cleared");
        chk_data("ferr_nodata");

        // Address errors leave no side effect.
        bus(24'h000010, 1'b0, 32'd0, rd, k, e);
        check("aerr_err", {31'd0, e}, 32'd1);
        check("aerr_ack", {31'd0, k}, 32'd0);
        @(posedge clk); #1;
        check("aerr_one_cycle", {30'd0, err, ack}, 32'd0);
        bus(24'h000010, 1'b1, 32'h77, rd, k, e);
        check("aerr_wr_err", {31'd0, e}, 32'd1);
        bus(24'h800004, 1'b0, 32'd0, rd, k, e);
        check("aerr_hi_err", {31'd0, e}, 32'd1);
        repeat (2) @(posedge clk);
        chk_status("aerr_no_push");

        // Strobe held high: acks on alternate cycles.
        @(posedge clk); #1;
        adr = A_STATUS; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
        pat = 6'd0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            pat[i] = ack;
        end
        cyc = 1'b0; stb = 1'b0;
        check("b2b_ack", {26'd0, pat}, 32'h15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
